mio_bus_arbiter: RTL

Shared data-memory controller that sits between the single-cycle CPU's memory port (CPU_MIO / MemRW / Addr_out / Data_out / Data_in / MIO_ready) and a single-port synchronous data RAM. A second requester, the debug/program loader port, also uses that RAM. The block arbitrates between the two requesters round-robin and sequences each access through a fixed number of RAM wait cycles. It returns read data plus a one-cycle ready pulse that the CPU uses as MIO_ready to stall.

---
 rtl/mio_bus_arbiter_if.sv | 49 ++++
 rtl/mio_bus_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mio_bus_arbiter_if.sv
// Bus bundle between the two requesters (CPU memory port, debug/loader port),
// the shared single-port data RAM and the arbiter that sits in the middle.
interface mio_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner_dbg;

  // The arbiter is the slave of both requesters and drives the RAM side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner_dbg
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner_dbg
  );
endinterface

// File: rtl/mio_bus_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU memory
// port and the debug/loader port; each access holds mem_en for WAIT_CYCLES.
module mio_bus_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic              clk,
  input logic              rst,
  mio_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              winner_q, winner_d;
  logic              last_winner_q, last_winner_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              dbg_ready_q, dbg_ready_d;
  logic              owner_dbg_q, owner_dbg_d;
  logic              grant_dbg;

  // winner encoding: 1 = debug port; on a tie the previous loser wins
  assign grant_dbg = (bus.cpu_req && bus.dbg_req) ? ~last_winner_q : bus.dbg_req;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    we_d          = we_q;
    mem_en_d      = mem_en_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    dbg_rdata_d   = dbg_rdata_q;
    cpu_ready_d   = 1'b0;
    dbg_ready_d   = 1'b0;
    owner_dbg_d   = owner_dbg_q;

    unique case (state_q)
      IDLE: begin
        owner_dbg_d = 1'b0;
        if (bus.cpu_req || bus.dbg_req) begin
          state_d     = ACCESS;
          cnt_d       = CNT_LOAD;
          winner_d    = grant_dbg;
          we_d        = grant_dbg ? bus.dbg_we    : bus.cpu_we;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
          mem_addr_d  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
          mem_wdata_d = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
          owner_dbg_d = grant_dbg;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d     = DONE;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          cpu_ready_d = ~winner_q;
          dbg_ready_d = winner_q;
          // read data is captured on the edge that closes the access
          if (!we_q) begin
            if (winner_q) dbg_rdata_d = bus.mem_rdata;
            else          cpu_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d       = IDLE;
        last_winner_d = winner_q;
        owner_dbg_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      winner_q      <= 1'b0;
      last_winner_q <= 1'b1;
      we_q          <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_rdata_q   <= '0;
      dbg_rdata_q   <= '0;
      cpu_ready_q   <= 1'b0;
      dbg_ready_q   <= 1'b0;
      owner_dbg_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      we_q          <= we_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
      cpu_ready_q   <= cpu_ready_d;
      dbg_ready_q   <= dbg_ready_d;
      owner_dbg_q   <= owner_dbg_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dbg_ready = dbg_ready_q;
  assign bus.owner_dbg = owner_dbg_q;

endmodule
